// File: rtl/munoc_probe_initiator.sv
// rtl/munoc_probe_initiator.sv - single-burst AXI-style probe initiator with response checking
module munoc_probe_initiator #(
  parameter int BW_ADDR = 32,
  parameter int BW_DATA = 32,
  parameter int BW_LEN  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [BW_ADDR-1:0] cmd_addr,
  input  logic [BW_LEN-1:0]  cmd_len,
  input  logic [BW_DATA-1:0] cmd_wdata,
  output logic [BW_ADDR-1:0] axaddr,
  output logic [BW_LEN-1:0]  axlen,
  output logic               awvalid,
  input  logic               awready,
  output logic               wvalid,
  input  logic               wready,
  output logic [BW_DATA-1:0] wdata,
  output logic               wlast,
  input  logic               bvalid,
  output logic               bready,
  input  logic [1:0]         bresp,
  output logic               arvalid,
  input  logic               arready,
  input  logic               rvalid,
  output logic               rready,
  input  logic [BW_DATA-1:0] rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  output logic               done,
  output logic [4:0]         status,
  output logic [BW_DATA-1:0] rdata_xor
);

  localparam int BW_CNT = BW_LEN + 1;
  localparam int BW_TMO = $clog2(TIMEOUT + 1);
  localparam logic [BW_TMO-1:0] TMO_MAX = BW_TMO'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [BW_ADDR-1:0]   addr_q, addr_d;
  logic [BW_LEN-1:0]    len_q, len_d;
  logic [BW_DATA-1:0]   wdata_q, wdata_d;
  logic [BW_CNT-1:0]    beat_q, beat_d;
  logic [BW_TMO-1:0]    tmo_q, tmo_d;
  logic [4:0]           status_q, status_d;
  logic [BW_DATA-1:0]   xor_q, xor_d;

  logic last_beat;
  logic hs;
  logic waiting;
  logic abort;

  assign last_beat = (beat_q == {1'b0, len_q});
  assign abort     = waiting && !hs && (tmo_q == TMO_MAX);

  // Handshake of the channel owned by the current state; waiting marks states under timeout watch
  always_comb begin
    hs      = 1'b0;
    waiting = 1'b1;
    case (state_q)
      S_AW:    hs = awready;
      S_W:     hs = wready;
      S_B:     hs = bvalid;
      S_AR:    hs = arready;
      S_R:     hs = rvalid;
      default: waiting = 1'b0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      status_q <= '0;
      xor_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wdata_q  <= wdata_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      status_q <= status_d;
      xor_q    <= xor_d;
    end
  end

  // Next-state: one address phase, the data/response phase, then a single DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) state_d = cmd_write ? S_AW : S_AR;
      S_AW:   if (awready) state_d = S_W;
      S_W:    if (wready && last_beat) state_d = S_B;
      S_B:    if (bvalid) state_d = S_DONE;
      S_AR:   if (arready) state_d = S_R;
      S_R:    if (rvalid && (rlast || last_beat)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_DONE;
  end

  // Datapath: command latch, beat/data counting, response accumulation and timeout counter
  always_comb begin
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    beat_d   = beat_q;
    status_d = status_q;
    xor_d    = xor_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          wdata_d  = cmd_wdata;
          beat_d   = '0;
          status_d = '0;
          xor_d    = '0;
        end
      end
      S_W: begin
        if (wready) begin
          beat_d  = beat_q + BW_CNT'(1);
          wdata_d = wdata_q + BW_DATA'(1);
        end
      end
      S_B: begin
        if (bvalid && (bresp > status_q[1:0])) status_d[1:0] = bresp;
      end
      S_R: begin
        if (rvalid) begin
          xor_d  = xor_q ^ rdata;
          beat_d = beat_q + BW_CNT'(1);
          if (rresp > status_q[1:0]) status_d[1:0] = rresp;
          if (rlast && !last_beat) status_d[3] = 1'b1;
          if (!rlast && last_beat) status_d[2] = 1'b1;
        end
      end
      default: ;
    endcase
    if (abort) status_d[4] = 1'b1;

    if ((state_d != state_q) || hs) tmo_d = '0;
    else if (waiting)               tmo_d = tmo_q + BW_TMO'(1);
    else                            tmo_d = tmo_q;
  end

  // Outputs decoded from state; a timeout drops every valid/ready by leaving the phase state
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    awvalid   = (state_q == S_AW);
    wvalid    = (state_q == S_W);
    wlast     = (state_q == S_W) && last_beat;
    bready    = (state_q == S_B);
    arvalid   = (state_q == S_AR);
    rready    = (state_q == S_R);
    done      = (state_q == S_DONE);
    axaddr    = addr_q;
    axlen     = len_q;
    wdata     = wdata_q;
    status    = status_q;
    rdata_xor = xor_q;
  end

endmodule

// File: tb/tb_munoc_probe_initiator.sv
// tb/tb_munoc_probe_initiator.sv - table-driven bench for munoc_probe_initiator
module tb_munoc_probe_initiator;

  logic        clk;
  logic        rstnn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [7:0]  cmd_len;
  logic [31:0] axaddr;
  logic [7:0]  axlen;
  logic        awvalid, awready, wvalid, wready, wlast;
  logic [31:0] wdata;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        done;
  logic [4:0]  status;
  logic [31:0] rdata_xor;

  int total = 0;
  int bad   = 0;

  munoc_probe_initiator #(
    .BW_ADDR(32), .BW_DATA(32), .BW_LEN(8), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rstnn(rstnn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .axaddr(axaddr), .axlen(axlen),
    .awvalid(awvalid), .awready(awready),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .done(done), .status(status), .rdata_xor(rdata_xor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              wr;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [31:0]     wd;
    bit              bp;
    bit              bv;
    logic [1:0]      bresp;
    logic [3:0][31:0] rd;
    logic [3:0][1:0]  rr;
    int              rlast_at;
    logic [4:0]      st;
    logic [31:0]     xr;
    int              beats;
    int              blat;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0][31:0] rd4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [3:0][1:0] rr4(input logic [1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_wdata = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
  endtask

  task automatic run(input vec_t v);
    int beat, cyc, cyc_b;
    bit fin, aw_wait, ar_wait, w_wait;
    logic [31:0] wprev, wexp;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len; cmd_wdata = v.wd;
    @(negedge clk);
    cmd_valid = 0;
    check("cmd_ready_busy", cmd_ready, 0);
    beat = 0; cyc = 0; cyc_b = -1; fin = 0;
    aw_wait = 0; ar_wait = 0; w_wait = 0; wprev = 0;
    while (!fin) begin
      if (cyc >= 300) begin
        total++; bad++;
        $display("FAIL budget: done=0 after %0d cycles, required done=1", cyc);
        break;
      end
      if (aw_wait) check("awvalid_held", awvalid, 1);
      if (ar_wait) check("arvalid_held", arvalid, 1);
      if (w_wait)  check("wvalid_held", wvalid, 1);
      if (done) begin
        fin = 1;
      end else begin
        awready = v.bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        wready  = v.bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        arready = v.bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (awvalid || arvalid) begin
          check("axaddr", axaddr, v.addr);
          check("axlen", axlen, v.len);
        end
        if (wvalid) begin
          wexp = v.wd + 32'(beat);
          check("wdata", wdata, wexp);
          check("wlast", wlast, beat == int'(v.len));
          if (w_wait) check("wdata_stable", wdata, wprev);
        end
        bvalid = bready && v.bv;
        bresp  = v.bresp;
        if (bready && cyc_b < 0) cyc_b = cyc;
        rvalid = rready;
        rdata  = v.rd[beat & 3];
        rresp  = v.rr[beat & 3];
        rlast  = (beat == v.rlast_at);
        aw_wait = awvalid && !awready;
        ar_wait = arvalid && !arready;
        w_wait  = wvalid && !wready;
        wprev   = wdata;
        if (wvalid && wready) beat++;
        if (rvalid && rready) beat++;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    idle_inputs();
    check("status", status, v.st);
    check("rdata_xor", rdata_xor, v.xr);
    check("beats", beat, v.beats);
    check("bready_at_done", bready, 0);
    if (v.blat >= 0) check("b_to_done_cycles", cyc - cyc_b, v.blat);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("cmd_ready_back", cmd_ready, 1);
    check("status_held", status, v.st);
    check("rdata_xor_held", rdata_xor, v.xr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_wvalid"}, wvalid, 0);
    check({tag, "_wlast"}, wlast, 0);
    check({tag, "_bready"}, bready, 0);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_rready"}, rready, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_status"}, status, 0);
    check({tag, "_rdata_xor"}, rdata_xor, 0);
    check({tag, "_axaddr"}, axaddr, 0);
    check({tag, "_axlen"}, axlen, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    bit seen_done;
    //          wr  addr          len   wd             bp  bv  bresp
    vec[0] = '{1'b1, 32'h100,  8'd3, 32'hA0,       1'b0, 1'b1, 2'd0,
               rd4(0, 0, 0, 0), rr4(0, 0, 0, 0), -1, 5'h00, 32'h0, 4, 1};
    vec[1] = '{1'b0, 32'h2000, 8'd1, 32'h0,        1'b0, 1'b0, 2'd0,
               rd4(32'h5, 32'h3, 0, 0), rr4(0, 2, 0, 0), 1, 5'h02, 32'h6, 2, -1};
    vec[2] = '{1'b0, 32'h3000, 8'd3, 32'h0,        1'b0, 1'b0, 2'd0,
               rd4(32'h11, 32'h22, 32'h44, 32'h88), rr4(0, 1, 0, 0), 1, 5'h09, 32'h33, 2, -1};
    vec[3] = '{1'b0, 32'h40,   8'd1, 32'h0,        1'b0, 1'b0, 2'd0,
               rd4(32'hF0, 32'h0F, 0, 0), rr4(1, 0, 0, 0), 7, 5'h05, 32'hFF, 2, -1};
    vec[4] = '{1'b0, 32'h44,   8'd0, 32'h0,        1'b0, 1'b0, 2'd0,
               rd4(32'hDEADBEEF, 0, 0, 0), rr4(3, 0, 0, 0), 0, 5'h03, 32'hDEADBEEF, 1, -1};
    vec[5] = '{1'b1, 32'h80,   8'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 2'd3,
               rd4(0, 0, 0, 0), rr4(0, 0, 0, 0), -1, 5'h03, 32'h0, 1, 1};
    vec[6] = '{1'b1, 32'h90,   8'd2, 32'hFFFFFFFE, 1'b1, 1'b1, 2'd1,
               rd4(0, 0, 0, 0), rr4(0, 0, 0, 0), -1, 5'h01, 32'h0, 3, 1};
    vec[7] = '{1'b0, 32'h1000, 8'd3, 32'h0,        1'b1, 1'b0, 2'd0,
               rd4(32'h1, 32'h2, 32'h4, 32'h8), rr4(0, 1, 0, 1), 3, 5'h01, 32'hF, 4, -1};
    vec[8] = '{1'b1, 32'h500,  8'd0, 32'h7,        1'b0, 1'b0, 2'd0,
               rd4(0, 0, 0, 0), rr4(0, 0, 0, 0), -1, 5'h10, 32'h0, 1, 16};

    idle_inputs();
    rstnn = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstnn = 1;

    for (int i = 0; i < NV; i++) run(vec[i]);

    // Reset in the middle of a write burst: everything clears at once, no done pulse
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h200; cmd_len = 8'd3; cmd_wdata = 32'h55;
    awready = 1; wready = 0;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    check("wvalid_before_reset", wvalid, 1);
    check("wdata_before_reset", wdata, 32'h55);
    #2 rstnn = 0;
    #1 check_all_zero("async_reset");
    idle_inputs();
    repeat (2) @(negedge clk);
    rstnn = 1;
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check("no_done_after_reset", seen_done, 0);
    run(vec[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
